// File: rtl/multi_ctrl_pkg.sv
// multi_ctrl shared types: state encodings, opcode/funct and mux selects.
// MULTI_CTRL_ADDI_EN enables the addi path (IMMEX/IMMWB states).
package multi_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IMMEX  = 4'd11,
    S_IMMWB  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b11;
  localparam logic [1:0] ALU_NOR = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multi_ctrl_if.sv
// Control bus between multi_ctrl (master) and the MultiCPU datapath (slave).
// Instruction fields and status flow in, enables and mux selects flow out.
interface multi_ctrl_if;
  import multi_ctrl_pkg::*;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_we;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_ctl;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_we, pc_src, iord, mem_rd, mem_wr,
    output ir_we, reg_we, reg_dst, mem_to_reg,
    output alu_src_a, alu_src_b, alu_ctl,
    output state, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_we, pc_src, iord, mem_rd, mem_wr,
    input  ir_we, reg_we, reg_dst, mem_to_reg,
    input  alu_src_a, alu_src_b, alu_ctl,
    input  state, illegal
  );

endinterface

// File: rtl/multi_ctrl_alu_dec.sv
// R-type funct decoder: ALU operation plus a flag for supported functs.
// Shared by EXEC (operation) and DECODE (legality).
module alu_dec
  import multi_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [1:0] alu_ctl,
  output logic       valid
);

  always_comb begin
    alu_ctl = ALU_ADD;
    valid   = 1'b0;
    unique case (1'b1)
      (funct == FN_ADD): begin
        alu_ctl = ALU_ADD;
        valid   = 1'b1;
      end
      (funct == FN_SUB): begin
        alu_ctl = ALU_SUB;
        valid   = 1'b1;
      end
      (funct == FN_AND): begin
        alu_ctl = ALU_AND;
        valid   = 1'b1;
      end
      (funct == FN_NOR): begin
        alu_ctl = ALU_NOR;
        valid   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_ctrl.sv
// Multicycle Moore control unit for the MultiCPU datapath.
// Define MULTI_CTRL_ADDI_EN to build the addi (op 0x08) path.
module multi_ctrl
  import multi_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  multi_ctrl_if.master bus
);

  if (ADDR_W < 6) begin : g_w_chk
    $error("multi_ctrl: ADDR_W too small");
  end

  state_t     state_q;
  state_t     state_d;
  logic [1:0] fn_ctl;
  logic       fn_ok;
  logic       legal;

  alu_dec u_alu_dec (
    .funct   (bus.funct),
    .alu_ctl (fn_ctl),
    .valid   (fn_ok)
  );

  always_comb begin
    legal = 1'b0;
    case (bus.op)
      OP_RTYPE: legal = fn_ok;
      OP_LW,
      OP_SW,
      OP_BEQ,
      OP_J:     legal = 1'b1;
`ifdef MULTI_CTRL_ADDI_EN
      OP_ADDI:  legal = 1'b1;
`endif
      default:  legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_FETCH;
        if (legal) begin
          case (bus.op)
            OP_LW,
            OP_SW:    state_d = S_MEMADR;
            OP_RTYPE: state_d = S_EXEC;
            OP_BEQ:   state_d = S_BRANCH;
            OP_J:     state_d = S_JUMP;
`ifdef MULTI_CTRL_ADDI_EN
            OP_ADDI:  state_d = S_IMMEX;
`endif
            default:  state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:
        state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB: state_d = S_FETCH;
      S_MEMWR: if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MULTI_CTRL_ADDI_EN
      S_IMMEX:  state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  assign bus.state = state_q;

  always_comb begin
    bus.pc_we      = 1'b0;
    bus.pc_src     = PC_ALU;
    bus.iord       = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.ir_we      = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_B;
    bus.alu_ctl    = ALU_ADD;
    bus.illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        bus.mem_rd    = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.alu_ctl   = ALU_ADD;
        bus.pc_src    = PC_ALU;
        bus.ir_we     = bus.mem_ready;
        bus.pc_we     = bus.mem_ready;
      end
      // branch target computed speculatively into ALUOut
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH;
        bus.alu_ctl   = ALU_ADD;
        bus.illegal   = !legal;
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_ctl   = ALU_ADD;
      end
      S_MEMRD: begin
        bus.iord   = 1'b1;
        bus.mem_rd = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_we     = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        bus.iord   = 1'b1;
        bus.mem_wr = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_B;
        bus.alu_ctl   = fn_ctl;
      end
      S_RWB: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_B;
        bus.alu_ctl   = ALU_SUB;
        bus.pc_src    = PC_ALUOUT;
        bus.pc_we     = bus.zero;
      end
      S_JUMP: begin
        bus.pc_src = PC_JUMP;
        bus.pc_we  = 1'b1;
      end
`ifdef MULTI_CTRL_ADDI_EN
      S_IMMEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_ctl   = ALU_ADD;
      end
      S_IMMWB: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_ctrl.sv
// Self-checking bench for multi_ctrl: per-instruction state traces and
// output vectors from a reference model, with random memory stalls.
module tb_multi_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multi_ctrl_if bus();

  multi_ctrl #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] obs;
  assign obs = {bus.pc_we, bus.pc_src, bus.iord, bus.mem_rd,
                bus.mem_wr, bus.ir_we, bus.reg_we, bus.reg_dst,
                bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                bus.alu_ctl, bus.illegal};

  int sq_st[$];
  bit sq_rdy[$];

  function automatic bit legal_instr(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00)
      return fn inside {6'h20, 6'h22, 6'h24, 6'h27};
    if (op inside {6'h23, 6'h2B, 6'h04, 6'h02})
      return 1'b1;
`ifdef MULTI_CTRL_ADDI_EN
    if (op == 6'h08) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // bit map: pc_we pc_src iord mem_rd mem_wr ir_we reg_we
  //          reg_dst mem_to_reg src_a src_b alu_ctl illegal
  function automatic logic [15:0] exp_vec(int st, bit rdy, bit z,
                                          logic [5:0] op, logic [5:0] fn);
    logic [15:0] v;
    v = '0;
    case (st)
      1: begin
        v[11] = 1'b1; v[4:3] = 2'b01;
        v[9] = rdy; v[15] = rdy;
      end
      2: begin
        v[4:3] = 2'b11; v[0] = !legal_instr(op, fn);
      end
      3: begin v[5] = 1'b1; v[4:3] = 2'b10; end
      4: begin v[12] = 1'b1; v[11] = 1'b1; end
      5: begin v[8] = 1'b1; v[6] = 1'b1; end
      6: begin v[12] = 1'b1; v[10] = 1'b1; end
      7: begin
        v[5] = 1'b1;
        if (fn == 6'h22)      v[2:1] = 2'b01;
        else if (fn == 6'h24) v[2:1] = 2'b11;
        else if (fn == 6'h27) v[2:1] = 2'b10;
        else                  v[2:1] = 2'b00;
      end
      8: begin v[8] = 1'b1; v[7] = 1'b1; end
      9: begin
        v[5] = 1'b1; v[2:1] = 2'b01;
        v[14:13] = 2'b01; v[15] = z;
      end
      10: begin v[14:13] = 2'b10; v[15] = 1'b1; end
      11: begin v[5] = 1'b1; v[4:3] = 2'b10; end
      12: v[8] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic push_free(input int st);
    sq_st.push_back(st);
    sq_rdy.push_back(1'($urandom));
  endtask

  task automatic push_wait(input int st, input int w);
    for (int k = 0; k < w; k++) begin
      sq_st.push_back(st);
      sq_rdy.push_back(1'b0);
    end
    sq_st.push_back(st);
    sq_rdy.push_back(1'b1);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input int w_f, input int w_m);
    sq_st.delete();
    sq_rdy.delete();
    push_wait(1, w_f);
    push_free(2);
    if (!legal_instr(op, fn)) return;
    case (op)
      6'h23: begin push_free(3); push_wait(4, w_m); push_free(5); end
      6'h2B: begin push_free(3); push_wait(6, w_m); end
      6'h00: begin push_free(7); push_free(8); end
      6'h04: push_free(9);
      6'h02: push_free(10);
      6'h08: begin push_free(11); push_free(12); end
      default: ;
    endcase
  endtask

  // Entered just after a falling edge with FETCH expected.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input bit z, input int w_f, input int w_m,
                           input int cut, input string tag);
    logic [15:0] e;
    logic [3:0]  es;
    build(op, fn, w_f, w_m);
    bus.op    = op;
    bus.funct = fn;
    for (int i = 0; i < sq_st.size() && i < cut; i++) begin
      bus.mem_ready = sq_rdy[i];
      bus.zero      = (sq_st[i] == 9) ? z : 1'($urandom);
      #1;
      es = sq_st[i][3:0];
      e  = exp_vec(sq_st[i], sq_rdy[i], bus.zero, op, fn);
      checks++;
      if (bus.state !== es) begin
        errors++;
        $display("FAIL %s state step %0d: got %0d want %0d",
                 tag, i, bus.state, es);
      end
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s outputs step %0d (state %0d): got %h want %h",
                 tag, i, es, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.op = 6'h00; bus.funct = 6'h20;
    bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0 || obs !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold: state %0d out %h want 0/0000",
               bus.state, obs);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0) begin
      errors++;
      $display("FAIL reset_release: state %0d want 0", bus.state);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd1 || bus.pc_we !== 1'b1 || bus.ir_we !== 1'b1) begin
      errors++;
      $display("FAIL first_fetch: state %0d pc_we %b ir_we %b want 1/1/1",
               bus.state, bus.pc_we, bus.ir_we);
    end
  endtask

  task automatic test_lw_wait();
    run_instr(6'h23, 6'h00, 1'b0, 0, 2, 99, "lw_wait");
  endtask

  task automatic test_rtype();
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, 99, "r_add");
    run_instr(6'h00, 6'h22, 1'b0, 1, 0, 99, "r_sub");
    run_instr(6'h00, 6'h24, 1'b0, 0, 0, 99, "r_and");
    run_instr(6'h00, 6'h27, 1'b0, 2, 0, 99, "r_nor");
  endtask

  task automatic test_branch_jump();
    run_instr(6'h04, 6'h11, 1'b1, 0, 0, 99, "beq_taken");
    run_instr(6'h04, 6'h11, 1'b0, 0, 0, 99, "beq_not");
    run_instr(6'h02, 6'h3C, 1'b0, 0, 0, 99, "jump");
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 99, "ill_op");
    run_instr(6'h00, 6'h25, 1'b0, 0, 0, 99, "ill_funct");
    run_instr(6'h08, 6'h05, 1'b0, 0, 0, 99, "addi");
    run_instr(6'h2B, 6'h00, 1'b0, 1, 3, 99, "sw_wait");
  endtask

  task automatic test_random();
    logic [5:0] op;
    logic [5:0] fn;
    logic [5:0] ops [6];
    logic [5:0] fns [4];
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};
    fns = '{6'h20, 6'h22, 6'h24, 6'h27};
    for (int n = 0; n < 40; n++) begin
      case ($urandom % 8)
        0, 1, 2, 3, 4: begin
          op = ops[$urandom % 6];
          fn = fns[$urandom % 4];
        end
        5: begin op = 6'($urandom); fn = fns[$urandom % 4]; end
        6: begin op = 6'h00; fn = 6'($urandom); end
        default: begin op = ops[$urandom % 6]; fn = 6'($urandom); end
      endcase
      run_instr(op, fn, 1'($urandom), int'($urandom % 3),
                int'($urandom % 4), 99, "random");
    end
  endtask

  task automatic test_async_reset();
    run_instr(6'h2B, 6'h00, 1'b0, 0, 0, 3, "sw_pre");
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd6 || bus.mem_wr !== 1'b1) begin
      errors++;
      $display("FAIL memwr_wait: state %0d mem_wr %b want 6/1",
               bus.state, bus.mem_wr);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.mem_wr !== 1'b0 || obs !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: state %0d mem_wr %b out %h want 0/0/0000",
               bus.state, bus.mem_wr, obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, 99, "post_reset_j");
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_rtype();
    test_branch_jump();
    test_illegal();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_ctrl.md
# multi_ctrl

Multicycle control unit for the MultiCPU datapath. It is the producer side of the ALU's 2-bit `alu_ctl` interface. A Moore state machine decodes `op` and `funct` of the latched instruction. It sequences PC, instruction register, memory, register file and ALU operand muxes through fetch/decode/execute/writeback steps, and stalls on memory via a ready handshake.

## Interface
- `ADDR_W`, 32: datapath width. Documentation only; no port depends on it.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 6: IR[31:26]. Must be valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU result == 0. Sampled only in BRANCH.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pc_we` out 1: PC write enable.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `iord` out 1: memory address source. 0 = PC, 1 = ALUOut.
- `mem_rd`, `mem_wr` out 1: memory strobes. Held until `mem_ready`.
- `ir_we` out 1: instruction register load.
- `reg_we` out 1: register file write.
- `reg_dst` out 1: destination register. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: writeback source. 1 = MDR, 0 = ALUOut.
- `alu_src_a` out 1: 0 = PC, 1 = A register.
- `alu_src_b` out 2: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_ctl` out 2: 00 = add, 01 = sub, 11 = and, 10 = nor.
- `state` out 4: current state, for debug.
- `illegal` out 1: unsupported op or funct seen in DECODE.

## Operation
- States and encodings: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, IMMEX 11, IMMWB 12.
- Any output not listed for a state is 0.
- **RESET:** all outputs 0. Always goes to FETCH.
- **FETCH:**
  - Outputs: `mem_rd`=1, `alu_src_b`=01, `alu_ctl`=00, `pc_src`=00.
  - `ir_we` = `pc_we` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- **DECODE:**
  - Outputs: `alu_src_b`=11, `alu_ctl`=00 (branch target into ALUOut).
  - Next state by `op`: 0x23 or 0x2B → MEMADR; 0x00 → EXEC; 0x04 → BRANCH; 0x02 → JUMP; 0x08 → IMMEX (when enabled).
  - Any other `op`, or R-type with `funct` ∉ {0x20, 0x22, 0x24, 0x27}: `illegal`=1 and next state FETCH (the instruction is treated as a NOP).
- **MEMADR:** `alu_src_a`=1, `alu_src_b`=10, add. Next is MEMRD for lw, MEMWR for sw.
- **MEMRD:** `iord`=1, `mem_rd`=1. Waits on `mem_ready`, then MEMWB.
- **MEMWB:** `reg_we`=1, `mem_to_reg`=1, `reg_dst`=0. Then FETCH.
- **MEMWR:** `iord`=1, `mem_wr`=1. Waits on `mem_ready`, then FETCH.
- **EXEC:** `alu_src_a`=1, `alu_src_b`=00, `alu_ctl` from `funct`: 0x20 → 00, 0x22 → 01, 0x24 → 11, 0x27 → 10. Then RWB.
- **RWB:** `reg_we`=1, `reg_dst`=1. Then FETCH.
- **BRANCH:** `alu_src_a`=1, sub, `pc_src`=01, `pc_we`=`zero`. Then FETCH.
- **JUMP:** `pc_src`=10, `pc_we`=1. Then FETCH.
- **IMMEX:** `alu_src_a`=1, `alu_src_b`=10, add. Then IMMWB.
- **IMMWB:** `reg_we`=1, `reg_dst`=0. Then FETCH.

## Timing
- Only the state register is clocked. Outputs decode combinationally from `state`; only `mem_ready` and `zero` qualify outputs within a cycle.
- Asserting `rst_n` low forces RESET immediately, mid-instruction included, with all outputs 0. The first FETCH occurs one cycle after reset release.
- Cycle counts with `mem_ready` tied high:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Strobes and addresses stay stable throughout the wait.
- `mem_ready` is ignored in every state except FETCH, MEMRD and MEMWR.

## Configuration
- `MULTI_CTRL_ADDI_EN`:
  - Defined: op 0x08 is legal and runs DECODE → IMMEX → IMMWB.
  - Undefined: IMMEX and IMMWB are not built, and op 0x08 raises `illegal` in DECODE.

## Structure
- Package `multi_ctrl_pkg` holds:
  - the state encodings;
  - the opcode and funct constants;
  - the `alu_ctl` encodings ALU_ADD, ALU_SUB, ALU_AND, ALU_NOR;
  - the `alu_src_b` and `pc_src` encodings.
- Sub-module `alu_dec` maps `funct` to `alu_ctl` plus a valid flag. It is used by EXEC and by the DECODE legality check.

## Test plan
- Reset held, then released, with `mem_ready`=1: `state` shows 0, then 1. `pc_we`=`ir_we`=1 in the first FETCH.
- lw (op 0x23) with `mem_ready` low for 2 cycles in MEMRD: 7-cycle sequence 1,2,3,4,4,4,5. `reg_we`=1 and `mem_to_reg`=1 only in state 5.
- R-type with funct 0x20/0x22/0x24/0x27: `alu_ctl` in EXEC is 00/01/11/10. `reg_we`=1 with `reg_dst`=1 in RWB.
- beq with `zero`=1, then `zero`=0: `pc_we`=1, then 0, in BRANCH, with `pc_src`=01. Returns to FETCH.
- op 0x3F, and R-type funct 0x25: `illegal`=1 in DECODE, next state 1, no enable asserted.
- `rst_n` pulled low during MEMWR: `state` becomes 0 and `mem_wr` goes 0 asynchronously, before the next clock edge.
